// File: rtl/cpu_bus_pkg.sv
// ----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU bus master: request size encodings, the
// access FSM state type and a helper that sizes the read-latency counter.
// ----------------------------------------------------------------------------
package cpu_bus_pkg;

  // reqSize encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // Width of a counter that must hold the values 1..wait_cycles.
  function automatic int wait_cnt_width(input int wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/bus_lane_unit.sv
// ----------------------------------------------------------------------------
// bus_lane_unit
// Purely combinational byte-lane logic for the CPU bus master.
//   i_addr_lo  : byte offset within the 32-bit word
//   i_size     : access size (SZ_BYTE / SZ_HALF / SZ_WORD / reserved)
//   i_signed   : sign-extend byte/half loads
//   i_wdata    : right-justified store data
//   i_rdata    : word read back from the bus
//   o_we       : per-byte write enables (bit n covers data[8n+7:8n])
//   o_wdata    : store data replicated across all lanes
//   o_rdata    : extracted and extended load data
//   o_misalign : access is misaligned or uses the reserved size
// ----------------------------------------------------------------------------
module bus_lane_unit
  import cpu_bus_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Split the read word into its four little-endian byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_addr_lo];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_we       = 4'b0000;
    o_wdata    = i_wdata;
    o_rdata    = 32'h0000_0000;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_we       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{i_signed & w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_we       = 4'b1111;
        o_rdata    = i_rdata;
        o_misalign = (i_addr_lo != 2'b00);
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_bus_master.sv
// ----------------------------------------------------------------------------
// cpu_bus_master
// Turns CPU load/store requests into single-cycle strobes on the CPU memory
// bus, waits out the fixed read latency, and returns extracted load data.
//   WAIT_CYCLES : cycles from the masterEN cycle to valid dataFromBus (>=1)
//   clk / rst   : clock, asynchronous active-high reset
//   req*        : CPU request (valid/ready handshake, fields sampled on accept)
//   rsp*        : one-cycle completion pulse with data and error flag
//   addrBus, masterEN, busWE, busWData : bus master outputs
//   dataFromBus : read data returned by the decoder mux
// ----------------------------------------------------------------------------
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        reqReady,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspError,
  output logic [31:0] addrBus,
  output logic        masterEN,
  output logic [3:0]  busWE,
  output logic [31:0] busWData,
  input  logic [31:0] dataFromBus
);

  localparam int              CNT_W    = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0] r_wait_cnt;

  // Request fields needed after the accept edge (load extraction, BUS exit).
  logic [1:0] r_addr_lo;
  logic [1:0] r_size;
  logic       r_signed;
  logic       r_write;

  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_error;
  logic [31:0] r_addr_bus;
  logic        r_master_en;
  logic [3:0]  r_bus_we;
  logic [31:0] r_bus_wdata;

  logic        w_sel_req;
  logic        w_accept;
  logic        w_last_wait;
  logic        w_enter_resp;
  logic [1:0]  w_lane_addr;
  logic [1:0]  w_lane_size;
  logic        w_lane_signed;
  logic [3:0]  w_lane_we;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_misalign;

  // IDLE and RESP are the only states that take requests.
  assign w_sel_req = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign reqReady  = w_sel_req;

  // One lane unit serves both directions: while accepting it sees the live
  // request (error check, store alignment); while waiting it sees the
  // registered request so the load extraction uses the accepted fields.
  assign w_lane_addr   = w_sel_req ? reqAddr[1:0] : r_addr_lo;
  assign w_lane_size   = w_sel_req ? reqSize      : r_size;
  assign w_lane_signed = w_sel_req ? reqSigned    : r_signed;

  bus_lane_unit u_lane (
    .i_addr_lo  (w_lane_addr),
    .i_size     (w_lane_size),
    .i_signed   (w_lane_signed),
    .i_wdata    (reqWData),
    .i_rdata    (dataFromBus),
    .o_we       (w_lane_we),
    .o_wdata    (w_lane_wdata),
    .o_rdata    (w_lane_rdata),
    .o_misalign (w_misalign)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_wait  = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (reqValid) begin
          w_accept     = 1'b1;
          w_state_next = w_misalign ? ST_RESP : ST_BUS;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUS: begin
        w_state_next = r_write ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == CNT_LAST) begin
          w_last_wait  = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Every entry into RESP (including RESP->RESP on a back-to-back error)
  // produces exactly one rspValid pulse.
  assign w_enter_resp = (w_state_next == ST_RESP);

  // Output, counter and request-capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_addr_lo   <= 2'b00;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0000_0000;
      r_rsp_error <= 1'b0;
      r_addr_bus  <= 32'h0000_0000;
      r_master_en <= 1'b0;
      r_bus_we    <= 4'b0000;
      r_bus_wdata <= 32'h0000_0000;
    end else begin
      // Bus strobes are registered at accept so they appear in the BUS cycle.
      r_master_en <= w_accept & ~w_misalign;
      r_bus_we    <= (w_accept & ~w_misalign & reqWrite) ? w_lane_we : 4'b0000;
      r_rsp_valid <= w_enter_resp;
      r_rsp_error <= w_accept & w_misalign;

      if (w_accept) begin
        r_addr_lo <= reqAddr[1:0];
        r_size    <= reqSize;
        r_signed  <= reqSigned;
        r_write   <= reqWrite;
      end

      if (w_accept && !w_misalign) begin
        r_addr_bus <= {reqAddr[31:2], 2'b00};
      end

      if (w_accept && !w_misalign && reqWrite) begin
        r_bus_wdata <= w_lane_wdata;
      end

      if (r_state == ST_BUS) begin
        r_wait_cnt <= CNT_ONE;
      end else if ((r_state == ST_WAIT) && !w_last_wait) begin
        r_wait_cnt <= r_wait_cnt + CNT_ONE;
      end

      if (w_last_wait) begin
        r_rsp_data <= w_lane_rdata;
      end else if (w_enter_resp) begin
        r_rsp_data <= 32'h0000_0000;
      end
    end
  end

  assign rspValid = r_rsp_valid;
  assign rspData  = r_rsp_data;
  assign rspError = r_rsp_error;
  assign addrBus  = r_addr_bus;
  assign masterEN = r_master_en;
  assign busWE    = r_bus_we;
  assign busWData = r_bus_wdata;

endmodule

// File: tb/tb_cpu_bus_master.sv
// ----------------------------------------------------------------------------
// tb_cpu_bus_master
// Self-checking bench for cpu_bus_master. One instance runs at the default
// read latency, a second at WAIT_CYCLES=3 for the reset-abort scenario.
// ----------------------------------------------------------------------------
module tb_cpu_bus_master;

  localparam int W  = 1;
  localparam int W3 = 3;

  logic        clk;
  logic        rst, reqValid, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWData, dataFromBus;
  logic        reqReady, rspValid, rspError, masterEN;
  logic [31:0] rspData, addrBus, busWData;
  logic [3:0]  busWE;

  logic        rst3, reqValid3, reqWrite3, reqSigned3;
  logic [1:0]  reqSize3;
  logic [31:0] reqAddr3, reqWData3, dataFromBus3;
  logic        reqReady3, rspValid3, rspError3, masterEN3;
  logic [31:0] rspData3, addrBus3, busWData3;
  logic [3:0]  busWE3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        me1;
    logic [31:0] addr1;
    logic [3:0]  we1;
    logic [31:0] wd1;
    int          me_count;
    int          we_stray;
    int          rsp_cycle;
    int          rsp_count;
    logic [31:0] rsp_data;
    logic        rsp_err;
  } obs_t;

  cpu_bus_master #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
    .reqWData(reqWData), .reqReady(reqReady), .rspValid(rspValid),
    .rspData(rspData), .rspError(rspError), .addrBus(addrBus),
    .masterEN(masterEN), .busWE(busWE), .busWData(busWData),
    .dataFromBus(dataFromBus)
  );

  cpu_bus_master #(.WAIT_CYCLES(W3)) dut3 (
    .clk(clk), .rst(rst3), .reqValid(reqValid3), .reqWrite(reqWrite3),
    .reqSize(reqSize3), .reqSigned(reqSigned3), .reqAddr(reqAddr3),
    .reqWData(reqWData3), .reqReady(reqReady3), .rspValid(rspValid3),
    .rspData(rspData3), .rspError(rspError3), .addrBus(addrBus3),
    .masterEN(masterEN3), .busWE(busWE3), .busWData(busWData3),
    .dataFromBus(dataFromBus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what one access should produce, from the access rules.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] bus, output logic err,
                                output logic [3:0] we, output logic [31:0] wd,
                                output logic [31:0] rd);
    int a;
    logic [31:0] v;
    a   = int'(addr[1:0]);
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && a != 0);
    we  = 4'h0;
    wd  = wdata;
    v   = 32'h0;
    if (sz == 2'd0) begin
      we = 4'(1 << a);
      wd = (wdata & 32'hFF) * 32'h0101_0101;
      v  = (bus >> (8 * a)) & 32'hFF;
      if (sg && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      we = 4'(3 << a);
      wd = (wdata & 32'hFFFF) * 32'h0001_0001;
      v  = (bus >> (8 * a)) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v - 32'h1_0000;
    end else if (sz == 2'd2) begin
      we = 4'hF;
      v  = bus;
    end
    rd = (wr || err) ? 32'h0 : v;
  endfunction

  // Drive one request on the default-latency DUT and record what the bus
  // and response side did in the cycles after accept. Starts and ends 1 time
  // unit after a rising edge.
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] bus, output obs_t o);
    o.me1 = 1'b0; o.addr1 = '0; o.we1 = '0; o.wd1 = '0;
    o.me_count = 0; o.we_stray = 0; o.rsp_cycle = -1; o.rsp_count = 0;
    o.rsp_data = '0; o.rsp_err = 1'b0;
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
    reqAddr = addr; reqWData = wdata; dataFromBus = $urandom;
    @(posedge clk); #1;
    // Scramble the request after accept; the DUT must ignore it.
    reqValid = 1'b0; reqWrite = 1'($urandom); reqSize = 2'($urandom);
    reqSigned = 1'($urandom); reqAddr = $urandom; reqWData = $urandom;
    for (int k = 1; k <= W + 4; k++) begin
      dataFromBus = (k == W + 1) ? bus : $urandom;
      @(negedge clk);
      if (k == 1) begin
        o.me1 = masterEN; o.addr1 = addrBus; o.we1 = busWE; o.wd1 = busWData;
      end else if (busWE !== 4'h0) begin
        o.we_stray++;
      end
      if (masterEN) o.me_count++;
      if (rspValid) begin
        o.rsp_count++;
        if (o.rsp_cycle < 0) begin
          o.rsp_cycle = k; o.rsp_data = rspData; o.rsp_err = rspError;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    reqValid = 0; reqWrite = 0; reqSize = 0; reqSigned = 0; reqAddr = 0; reqWData = 0; dataFromBus = 0;
    reqValid3 = 0; reqWrite3 = 0; reqSize3 = 0; reqSigned3 = 0; reqAddr3 = 0; reqWData3 = 0; dataFromBus3 = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rspValid !== 1'b0) begin n_bad++; $display("FAIL reset_rspValid got %b want 0", rspValid); end
    n_cmp++; if (rspError !== 1'b0) begin n_bad++; $display("FAIL reset_rspError got %b want 0", rspError); end
    n_cmp++; if (masterEN !== 1'b0) begin n_bad++; $display("FAIL reset_masterEN got %b want 0", masterEN); end
    n_cmp++; if (rspData !== 32'h0) begin n_bad++; $display("FAIL reset_rspData got %h want 0", rspData); end
    n_cmp++; if (addrBus !== 32'h0) begin n_bad++; $display("FAIL reset_addrBus got %h want 0", addrBus); end
    n_cmp++; if (busWData !== 32'h0) begin n_bad++; $display("FAIL reset_busWData got %h want 0", busWData); end
    n_cmp++; if (busWE !== 4'h0) begin n_bad++; $display("FAIL reset_busWE got %h want 0", busWE); end
    n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL reset_reqReady got %b want 1", reqReady); end
    rst = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL idle_reqReady got %b want 1", reqReady); end
    $display("reset: done");
  endtask

  task automatic test_word_load();
    obs_t o;
    run_access(1'b0, 2'b10, 1'b0, 32'hBFC0_0010, 32'h0, 32'hDEAD_BEEF, o);
    n_cmp++; if (o.me1 !== 1'b1) begin n_bad++; $display("FAIL wl_masterEN got %b want 1", o.me1); end
    n_cmp++; if (o.addr1 !== 32'hBFC0_0010) begin n_bad++; $display("FAIL wl_addrBus got %h want bfc00010", o.addr1); end
    n_cmp++; if (o.we1 !== 4'h0) begin n_bad++; $display("FAIL wl_busWE got %h want 0", o.we1); end
    n_cmp++; if (o.rsp_cycle != 3) begin n_bad++; $display("FAIL wl_rsp_cycle got %0d want 3", o.rsp_cycle); end
    n_cmp++; if (o.rsp_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wl_rspData got %h want deadbeef", o.rsp_data); end
    n_cmp++; if (o.rsp_err !== 1'b0) begin n_bad++; $display("FAIL wl_rspError got %b want 0", o.rsp_err); end
    n_cmp++; if (o.me_count != 1 || o.rsp_count != 1) begin n_bad++; $display("FAIL wl_pulses got me=%0d rsp=%0d want 1/1", o.me_count, o.rsp_count); end
    $display("word load: addr=bfc00010 data=%h", o.rsp_data);
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_access(1'b0, 2'b00, 1'b1, 32'hBFC0_4003, 32'h0, 32'h80FF_1234, o);
    n_cmp++; if (o.rsp_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL bl_signed got %h want ffffff80", o.rsp_data); end
    n_cmp++; if (o.addr1 !== 32'hBFC0_4000) begin n_bad++; $display("FAIL bl_addrBus got %h want bfc04000", o.addr1); end
    $display("byte load signed: data=%h", o.rsp_data);
    run_access(1'b0, 2'b00, 1'b0, 32'hBFC0_4003, 32'h0, 32'h80FF_1234, o);
    n_cmp++; if (o.rsp_data !== 32'h0000_0080) begin n_bad++; $display("FAIL bl_unsigned got %h want 00000080", o.rsp_data); end
    $display("byte load unsigned: data=%h", o.rsp_data);
  endtask

  task automatic test_half_store();
    obs_t o;
    run_access(1'b1, 2'b01, 1'b0, 32'hBFC0_9002, 32'h0000_ABCD, 32'h0, o);
    n_cmp++; if (o.wd1 !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL hs_busWData got %h want abcdabcd", o.wd1); end
    n_cmp++; if (o.we1 !== 4'b1100) begin n_bad++; $display("FAIL hs_busWE got %b want 1100", o.we1); end
    n_cmp++; if (o.addr1 !== 32'hBFC0_9000) begin n_bad++; $display("FAIL hs_addrBus got %h want bfc09000", o.addr1); end
    n_cmp++; if (o.rsp_cycle != 2) begin n_bad++; $display("FAIL hs_rsp_cycle got %0d want 2", o.rsp_cycle); end
    n_cmp++; if (o.rsp_data !== 32'h0) begin n_bad++; $display("FAIL hs_rspData got %h want 0", o.rsp_data); end
    n_cmp++; if (o.we_stray != 0) begin n_bad++; $display("FAIL hs_busWE_outside_bus got %0d want 0", o.we_stray); end
    $display("half store: we=%b wdata=%h", o.we1, o.wd1);
  endtask

  task automatic test_errors();
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) run_access(1'b0, 2'b10, 1'b0, 32'hBFC0_0002, 32'h0, 32'h1234_5678, o);
      else        run_access(1'b0, 2'b11, 1'b0, 32'hBFC0_0000, 32'h0, 32'h1234_5678, o);
      n_cmp++; if (o.me_count != 0) begin n_bad++; $display("FAIL err%0d_masterEN got %0d pulses want 0", i, o.me_count); end
      n_cmp++; if (o.rsp_cycle != 1) begin n_bad++; $display("FAIL err%0d_rsp_cycle got %0d want 1", i, o.rsp_cycle); end
      n_cmp++; if (o.rsp_err !== 1'b1) begin n_bad++; $display("FAIL err%0d_rspError got %b want 1", i, o.rsp_err); end
      n_cmp++; if (o.rsp_data !== 32'h0) begin n_bad++; $display("FAIL err%0d_rspData got %h want 0", i, o.rsp_data); end
      $display("error access %0d: rsp_cycle=%0d err=%b", i, o.rsp_cycle, o.rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  me_mask, rv_mask;
    logic [31:0] d1, d2, got1, got2;
    me_mask = '0; rv_mask = '0; got1 = '0; got2 = '0;
    d1 = $urandom; d2 = $urandom;
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0;
    reqAddr = 32'h0000_1000; reqWData = 32'h0;
    @(posedge clk); #1;
    reqAddr = 32'h0000_2004;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) reqValid = 1'b0;
      dataFromBus = (k == 2) ? d1 : ((k == 5) ? d2 : $urandom);
      @(negedge clk);
      me_mask[k] = masterEN;
      rv_mask[k] = rspValid;
      if (k == 3) got1 = rspData;
      if (k == 6) got2 = rspData;
      if (k == 4 && masterEN && addrBus !== 32'h0000_2004) begin
        n_bad++; $display("FAIL b2b_addr2 got %h want 00002004", addrBus);
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (me_mask !== 9'b0_0001_0010) begin n_bad++; $display("FAIL b2b_masterEN_cycles got %b want 000010010", me_mask); end
    n_cmp++; if (rv_mask !== 9'b0_0100_1000) begin n_bad++; $display("FAIL b2b_rspValid_cycles got %b want 001001000", rv_mask); end
    n_cmp++; if (got1 !== d1) begin n_bad++; $display("FAIL b2b_data1 got %h want %h", got1, d1); end
    n_cmp++; if (got2 !== d2) begin n_bad++; $display("FAIL b2b_data2 got %h want %h", got2, d2); end
    $display("back-to-back: me=%b rv=%b", me_mask, rv_mask);
  endtask

  task automatic test_random();
    obs_t o;
    logic wr, sg, err;
    logic [1:0] sz;
    logic [31:0] addr, wdata, bus, wd, rd;
    logic [3:0] we;
    int exp_cycle;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      addr = $urandom; wdata = $urandom; bus = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
        if (sz == 2'd2) addr = addr & 32'hFFFF_FFFC;
      end
      model(wr, sz, sg, addr, wdata, bus, err, we, wd, rd);
      exp_cycle = err ? 1 : (wr ? 2 : 2 + W);
      run_access(wr, sz, sg, addr, wdata, bus, o);
      n_cmp++; if (o.rsp_cycle != exp_cycle) begin n_bad++; $display("FAIL rnd%0d_rsp_cycle got %0d want %0d", i, o.rsp_cycle, exp_cycle); end
      n_cmp++; if (o.rsp_data !== rd) begin n_bad++; $display("FAIL rnd%0d_rspData got %h want %h", i, o.rsp_data, rd); end
      n_cmp++; if (o.rsp_err !== err) begin n_bad++; $display("FAIL rnd%0d_rspError got %b want %b", i, o.rsp_err, err); end
      n_cmp++; if (o.me_count != (err ? 0 : 1) || o.rsp_count != 1 || o.we_stray != 0) begin
        n_bad++; $display("FAIL rnd%0d_pulses got me=%0d rsp=%0d stray=%0d want %0d/1/0", i, o.me_count, o.rsp_count, o.we_stray, err ? 0 : 1);
      end
      if (!err) begin
        n_cmp++; if (o.addr1 !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL rnd%0d_addrBus got %h want %h", i, o.addr1, {addr[31:2], 2'b00}); end
        n_cmp++; if (o.we1 !== (wr ? we : 4'h0)) begin n_bad++; $display("FAIL rnd%0d_busWE got %h want %h", i, o.we1, wr ? we : 4'h0); end
        if (wr) begin
          n_cmp++; if (o.wd1 !== wd) begin n_bad++; $display("FAIL rnd%0d_busWData got %h want %h", i, o.wd1, wd); end
        end
      end
      $display("rnd %0d: wr=%b sz=%0d sg=%b addr=%h rsp=%h err=%b", i, wr, sz, sg, addr, o.rsp_data, o.rsp_err);
    end
  endtask

  task automatic test_reset_abort();
    int rsp_seen, first_rsp;
    logic [31:0] d;
    logic [31:0] got;
    reqValid3 = 1'b1; reqWrite3 = 1'b0; reqSize3 = 2'b10; reqSigned3 = 1'b0;
    reqAddr3 = 32'h0000_0040; reqWData3 = 32'h0; dataFromBus3 = $urandom;
    @(posedge clk); #1;
    reqValid3 = 1'b0;
    // Cycle 1 is BUS, cycle 2 first WAIT; advance into cycle 3 (second WAIT).
    repeat (2) begin @(posedge clk); #1; end
    rst3 = 1'b1;
    #1;
    n_cmp++; if (masterEN3 !== 1'b0) begin n_bad++; $display("FAIL abort_masterEN got %b want 0", masterEN3); end
    n_cmp++; if (rspValid3 !== 1'b0) begin n_bad++; $display("FAIL abort_rspValid got %b want 0", rspValid3); end
    n_cmp++; if (reqReady3 !== 1'b1) begin n_bad++; $display("FAIL abort_reqReady got %b want 1", reqReady3); end
    n_cmp++; if (busWE3 !== 4'h0) begin n_bad++; $display("FAIL abort_busWE got %h want 0", busWE3); end
    #1 rst3 = 1'b0;
    @(posedge clk); #1;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rspValid3) rsp_seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (rsp_seen != 0) begin n_bad++; $display("FAIL abort_no_rsp got %0d pulses want 0", rsp_seen); end
    d = $urandom;
    reqValid3 = 1'b1; reqAddr3 = 32'h0000_0080;
    @(posedge clk); #1;
    reqValid3 = 1'b0;
    first_rsp = -1; got = '0;
    for (int k = 1; k <= 8; k++) begin
      dataFromBus3 = (k == 1 + W3) ? d : $urandom;
      @(negedge clk);
      if (rspValid3 && first_rsp < 0) begin first_rsp = k; got = rspData3; end
      @(posedge clk); #1;
    end
    n_cmp++; if (first_rsp != 2 + W3) begin n_bad++; $display("FAIL abort_new_load_cycle got %0d want %0d", first_rsp, 2 + W3); end
    n_cmp++; if (got !== d) begin n_bad++; $display("FAIL abort_new_load_data got %h want %h", got, d); end
    $display("reset abort: new load rsp_cycle=%0d data=%h", first_rsp, got);
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Upstream bus master that turns CPU load/store requests into cycles on the CPU memory bus, ahead of the address decoder / read mux. Drives `addrBus`/`masterEN` for exactly one cycle per access, waits out the registered read latency of decoder plus slaves, then returns lane-extracted, sign/zero-extended load data. Aligns store data onto byte lanes with per-byte write enables. Rejects misaligned accesses without touching the bus.

## Interface
- `WAIT_CYCLES`, 1, cycles from the `masterEN` cycle to valid `dataFromBus`; legal values are ≥1.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqValid` in 1: CPU request present.
- `reqWrite` in 1: 1 = store, 0 = load.
- `reqSize` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `reqSigned` in 1: sign-extend load (byte/half only).
- `reqAddr` in 32: byte address.
- `reqWData` in 32: store data, right-justified.
- `reqReady` out 1: request accepted on edge where `reqValid & reqReady`.
- `rspValid` out 1: one-cycle completion pulse.
- `rspData` out 32: load result; 0 for stores/errors.
- `rspError` out 1: misaligned/reserved size, valid with `rspValid`.
- `addrBus` out 32: bus address, word-aligned (`[1:0]`=0).
- `masterEN` out 1: bus access strobe.
- `busWE` out 4: byte write enables, bit n = `data[8n+7:8n]`.
- `busWData` out 32: lane-replicated store data.
- `dataFromBus` in 32: read data from the decoder mux.

## Operation
- States: IDLE, BUS, WAIT, RESP. `reqReady` = 1 in IDLE and RESP, else 0.
- Accept (IDLE/RESP, `reqValid`):
  - Error check: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11. On error, go to RESP with `rspError`=1 and `rspData`=0; no bus cycle.
  - Otherwise, go to BUS.
- BUS (1 cycle): `masterEN`=1, `addrBus`={addr[31:2],2'b00}.
  - Store: `busWE` and `busWData` are valid in the same cycle; next state RESP.
  - Load: `busWE`=0; next state WAIT.
- WAIT: counter runs 1..`WAIT_CYCLES`. On the last WAIT cycle, capture the extracted `dataFromBus` into `rspData`; next state RESP.
- RESP: `rspValid`=1 for one cycle. Accepts a new request (back-to-back); otherwise returns to IDLE.
- Load extract (little-endian):
  - Byte = `data[8·a+7:8·a]`, a=`addr[1:0]`.
  - Half = `addr[1]` ? `[31:16]` : `[15:0]`.
  - Zero- or sign-extend per `reqSigned`; word passes through unchanged.
- Store align:
  - Byte: {4{wdata[7:0]}}, `busWE`=1<<a.
  - Half: {2{wdata[15:0]}}, `busWE`=`addr[1]` ? 1100 : 0011.
  - Word: `busWE`=1111.
- Outside BUS, `masterEN`=0 and `busWE`=0. `addrBus`/`busWData` hold their last value.
- Request fields are registered at accept; input changes after accept are ignored.

## Timing
- All outputs except `reqReady` come from registers; `reqReady` is decoded from the state register.
- Reset values: `rspValid`, `rspError`, `masterEN` = 0; `rspData`, `addrBus`, `busWData` = 0; `busWE`=0; state IDLE, so `reqReady`=1.
- Latency, with accept on the edge closing cycle 0:
  - Load: BUS cycle 1; `rspValid` in cycle 2+`WAIT_CYCLES` (3 at default).
  - Store: `rspValid` in cycle 2.
  - Error: `rspValid` in cycle 1.
- Back-to-back: a request accepted in the RESP cycle gets BUS in the following cycle. Peak throughput is one load per 2+`WAIT_CYCLES` cycles.
- Reset asserted mid-access: the access is abandoned immediately (async). `masterEN`/`busWE`/`rspValid` drop to 0, no response is ever issued, and the FSM returns to IDLE.

## Structure
- Package `cpu_bus_pkg`: `reqSize` encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, WAIT counter width derived via $clog2(`WAIT_CYCLES`+1).
- Sub-module `bus_lane_unit` (combinational):
  - Inputs `addr[1:0]`, size, signed, wdata, bus data.
  - Outputs `busWE`, replicated wdata, extracted load data, misalign flag.
- Top module holds the FSM, counter and output registers.

## Test plan
- Word load 0xBFC00010, `dataFromBus`=0xDEADBEEF in cycle 2 → cycle 1 `masterEN`=1, `addrBus`=0xBFC00010, `busWE`=0; cycle 3 `rspValid`=1, `rspData`=0xDEADBEEF, `rspError`=0.
- Byte load 0xBFC04003, bus=0x80FF1234 → signed `rspData`=0xFFFFFF80; unsigned `rspData`=0x00000080.
- Half store 0xBFC09002, wdata 0x0000ABCD → cycle 1 `busWData`=0xABCDABCD, `busWE`=1100, `addrBus`=0xBFC09000; cycle 2 `rspValid`=1, `rspData`=0.
- Misaligned word load 0xBFC00002, and size=11 → `masterEN` never asserted; cycle 1 `rspValid`=1, `rspError`=1, `rspData`=0.
- `reqValid` held for two loads → second accepted in the first RESP cycle; `masterEN` pulses in cycles 1 and 4, `rspValid` in cycles 3 and 6.
- `WAIT_CYCLES`=3, `rst` pulsed in the second WAIT cycle → `masterEN`/`rspValid` 0 at once; `reqReady`=1; no `rspValid` for the aborted load. A new load then completes in 5 cycles.
